// File: rtl/full_adder_bist.sv
// ---------------------------------------------------------------------------
// full_adder_bist : exhaustive on-chip self-test of a combinational full adder
// Revision 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module full_adder_bist #(
  parameter int SETTLE_CYCLES = 1,
  parameter int ERR_W         = 4
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  output logic             A,
  output logic             B,
  output logic             CARRY_IN,
  input  logic             SUM,
  input  logic             CARRY_OUT,
  output logic             BUSY,
  output logic             DONE,
  output logic             PASS,
  output logic [ERR_W-1:0] ERR_COUNT,
  output logic             FAIL_VALID,
  output logic [2:0]       FAIL_VECTOR
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    CHECK  = 2'd2,
    FINISH = 2'd3
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic [2:0]       vec_q, vec_d;
  logic [3:0]       settle_q, settle_d;
  logic [ERR_W-1:0] err_q, err_d;
  logic             fail_valid_q, fail_valid_d;
  logic [2:0]       fail_vec_q, fail_vec_d;
  logic             pass_q, pass_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic exp_sum, exp_co, mismatch;

  assign exp_sum  = ^vec_q;
  assign exp_co   = (vec_q[2] & vec_q[1]) | (vec_q[2] & vec_q[0]) | (vec_q[1] & vec_q[0]);
  assign mismatch = (SUM != exp_sum) || (CARRY_OUT != exp_co);

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q      <= IDLE;
      vec_q        <= 3'd0;
      settle_q     <= 4'd0;
      err_q        <= '0;
      fail_valid_q <= 1'b0;
      fail_vec_q   <= 3'd0;
      pass_q       <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      settle_q     <= settle_d;
      err_q        <= err_d;
      fail_valid_q <= fail_valid_d;
      fail_vec_q   <= fail_vec_d;
      pass_q       <= pass_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    settle_d     = settle_q;
    err_d        = err_q;
    fail_valid_d = fail_valid_q;
    fail_vec_d   = fail_vec_q;
    pass_d       = pass_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    case (state_q)
      // The DONE cycle already counts as idle: a held START restarts on the
      // edge that closes it, one cycle after the last check.
      IDLE, FINISH: begin
        if (START) begin
          state_d      = SETTLE;
          vec_d        = 3'd0;
          settle_d     = 4'd0;
          err_d        = '0;
          fail_valid_d = 1'b0;
          fail_vec_d   = 3'd0;
          pass_d       = 1'b0;
          busy_d       = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (settle_q == SETTLE_LAST) begin
          state_d = CHECK;
        end else begin
          settle_d = settle_q + 4'd1;
        end
      end
      CHECK: begin
        if (mismatch) begin
          if (err_q != {ERR_W{1'b1}}) begin
            err_d = err_q + 1'b1;
          end
          if (!fail_valid_q) begin
            fail_valid_d = 1'b1;
            fail_vec_d   = vec_q;
          end
        end
        if (vec_q == 3'd7) begin
          state_d = FINISH;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (err_d == '0);
        end else begin
          state_d  = SETTLE;
          vec_d    = vec_q + 3'd1;
          settle_d = 4'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign A           = vec_q[2];
  assign B           = vec_q[1];
  assign CARRY_IN    = vec_q[0];
  assign BUSY        = busy_q;
  assign DONE        = done_q;
  assign PASS        = pass_q;
  assign ERR_COUNT   = err_q;
  assign FAIL_VALID  = fail_valid_q;
  assign FAIL_VECTOR = fail_vec_q;

endmodule

`default_nettype wire

// File: tb/tb_full_adder_bist.sv
// ---------------------------------------------------------------------------
// tb_full_adder_bist : three BIST instances (S=1/ERR_W=4, S=1/ERR_W=3, S=3)
// against healthy and faulty adder models, with a result scoreboard.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_full_adder_bist;

  localparam int N = 3;
  localparam int SC [N] = '{1, 1, 3};
  localparam int EW [N] = '{4, 3, 4};

  typedef struct packed {
    logic [3:0] err;
    logic       fv;
    logic [2:0] fvec;
  } res_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;

  // 0 = healthy adder, 1 = SUM stuck at 0, 2 = CARRY_OUT inverted
  int mode [N];
  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0] vec_w  [N];
  logic       busy_w [N];
  logic       done_w [N];
  logic       pass_w [N];
  logic       fv_w   [N];
  logic [3:0] err_w  [N];
  logic [2:0] fvec_w [N];

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference result after the first n vectors have been checked.
  function automatic res_t calc(input int md, input int n, input int ew);
    res_t       r;
    int         cnt;
    logic [2:0] vv;
    logic       bad;
    r   = '0;
    cnt = 0;
    for (int v = 0; v < n; v++) begin
      vv  = 3'(v);
      bad = (md == 1 && (^vv)) || (md == 2);
      if (bad) begin
        if (!r.fv) begin
          r.fv   = 1'b1;
          r.fvec = vv;
        end
        cnt++;
      end
    end
    r.err = 4'((cnt > (1 << ew) - 1) ? (1 << ew) - 1 : cnt);
    return r;
  endfunction

  for (genvar g = 0; g < N; g++) begin : g_inst
    localparam int S    = SC[g];
    localparam int W    = EW[g];
    localparam int LAST = 8 * (S + 1);

    logic         a_w, b_w, c_w, sum_w, co_w;
    logic [W-1:0] ec;

    always_comb begin
      sum_w = a_w ^ b_w ^ c_w;
      co_w  = (a_w & b_w) | (a_w & c_w) | (b_w & c_w);
      if (mode[g] == 1) sum_w = 1'b0;
      if (mode[g] == 2) co_w = ~co_w;
    end

    full_adder_bist #(.SETTLE_CYCLES(S), .ERR_W(W)) u_dut (
      .CLK(clk), .RST_N(rst_n), .START(start),
      .A(a_w), .B(b_w), .CARRY_IN(c_w),
      .SUM(sum_w), .CARRY_OUT(co_w),
      .BUSY(busy_w[g]), .DONE(done_w[g]), .PASS(pass_w[g]),
      .ERR_COUNT(ec), .FAIL_VALID(fv_w[g]), .FAIL_VECTOR(fvec_w[g])
    );

    assign vec_w[g] = {a_w, b_w, c_w};
    assign err_w[g] = 4'(ec);

    // k = edges since the accepting edge; the DONE cycle is k == LAST.
    int         k         = 0;
    bit         run       = 1'b0;
    logic [2:0] lastv     = 3'd0;
    res_t       hold      = '0;
    logic       hold_pass = 1'b0;
    res_t       q [$];

    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        run = 1'b0; k = 0; lastv = 3'd0; hold = '0; hold_pass = 1'b0;
        q.delete();
      end else if (start && (!run || k == LAST)) begin
        run = 1'b1; k = 0;
        q.push_back(calc(mode[g], 8, W));
      end else if (run) begin
        if (k == LAST) begin
          run       = 1'b0;
          lastv     = 3'd7;
          hold      = calc(mode[g], 8, W);
          hold_pass = (hold.err == 4'd0);
        end else begin
          k++;
        end
      end
    end

    always @(negedge clk) begin
      res_t       e;
      logic [2:0] ev;
      logic       eb, ed, ep;
      if (run) begin
        e  = calc(mode[g], k / (S + 1), W);
        ev = (k < LAST) ? 3'(k / (S + 1)) : 3'd7;
        eb = (k < LAST);
        ed = (k == LAST);
        ep = 1'b0;
        if (ed) begin
          if (q.size() == 0) begin
            check($sformatf("u%0d_sb_underflow", g), 1, 0);
          end else begin
            e  = q.pop_front();
            ep = (e.err == 4'd0);
          end
        end
      end else begin
        e = hold; ev = lastv; eb = 1'b0; ed = 1'b0; ep = hold_pass;
      end
      check($sformatf("u%0d_vector", g), vec_w[g], ev);
      check($sformatf("u%0d_busy", g), busy_w[g], eb);
      check($sformatf("u%0d_done", g), done_w[g], ed);
      check($sformatf("u%0d_pass", g), pass_w[g], ep);
      check($sformatf("u%0d_err_count", g), err_w[g], e.err);
      check($sformatf("u%0d_fail_valid", g), fv_w[g], e.fv);
      check($sformatf("u%0d_fail_vector", g), fvec_w[g], e.fvec);
    end
  end

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  initial begin
    mode = '{0, 2, 0};
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // healthy adder on u0/u2, inverted carry on u1
    pulse_start();
    repeat (40) @(negedge clk);

    // SUM stuck at 0 on u0
    mode[0] = 1;
    pulse_start();
    repeat (40) @(negedge clk);

    // START held high: back-to-back runs
    mode[0] = 0;
    start   = 1'b1;
    repeat (40) @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);

    // asynchronous reset while u0 holds vector 3 in SETTLE
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    for (int g = 0; g < N; g++) begin
      check($sformatf("u%0d_rst_vector", g), vec_w[g], 0);
      check($sformatf("u%0d_rst_busy", g), busy_w[g], 0);
      check($sformatf("u%0d_rst_done", g), done_w[g], 0);
      check($sformatf("u%0d_rst_pass", g), pass_w[g], 0);
      check($sformatf("u%0d_rst_err", g), err_w[g], 0);
      check($sformatf("u%0d_rst_fail_valid", g), fv_w[g], 0);
      check($sformatf("u%0d_rst_fail_vector", g), fvec_w[g], 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse_start();
    repeat (40) @(negedge clk);

    check("u0_sb_pending", g_inst[0].q.size(), 0);
    check("u1_sb_pending", g_inst[1].q.size(), 0);
    check("u2_sb_pending", g_inst[2].q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
